mux16to1_collect: RTL and testbench

- Reverse-direction partner of the 1-to-16 function-select demux: gathers the N-bit result from one of 16 function-unit lanes (a0..a15), chosen by fn_sel.
- Returns the result to the CPU datapath through a registered valid/ready handshake.
- Waits for the selected lane to signal valid, times out if it never does, and flags out-of-range selects.

---
 rtl/mux16to1_collect.sv | 187 ++++++++++++++++++
 tb/tb_mux16to1_collect.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux16to1_collect.sv
`timescale 1ns/1ps
// mux16to1_collect
// ----------------
// Collects an N-bit result from one of 16 function-unit lanes and returns it
// to the datapath over a registered valid/ready handshake. A collect starts
// when req is seen in IDLE. The select is latched at that point. The block
// then waits for the chosen lane's valid bit, gives up after TIMEOUT cycles,
// and answers an out-of-range select with an immediate error response.
//
// Parameters:
//   N        lane / output data width
//   TIMEOUT  maximum WAIT cycles before a timeout response (>= 1)
//   CW       timeout counter width (2**CW must exceed TIMEOUT)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   a0..a15      lane result data
//   a_valid      per-lane valid bits
//   fn_sel       lane select, 0..15 legal, 16..31 illegal
//   req          start a collect (only looked at in IDLE)
//   out          collected data (0 for error responses)
//   out_valid    out/sel_err/timeout_err hold a response
//   out_ready    consumer accepts the response
//   sel_err      response is an illegal-select error
//   timeout_err  response is a timeout error
//   busy         block is not in IDLE
module mux16to1_collect #(
    parameter int N       = 16,
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [N-1:0] a4,
    input  logic [N-1:0] a5,
    input  logic [N-1:0] a6,
    input  logic [N-1:0] a7,
    input  logic [N-1:0] a8,
    input  logic [N-1:0] a9,
    input  logic [N-1:0] a10,
    input  logic [N-1:0] a11,
    input  logic [N-1:0] a12,
    input  logic [N-1:0] a13,
    input  logic [N-1:0] a14,
    input  logic [N-1:0] a15,
    input  logic [15:0]  a_valid,
    input  logic [4:0]   fn_sel,
    input  logic         req,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         sel_err,
    output logic         timeout_err,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [3:0]     sel_q, sel_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   out_q, out_d;
    logic           out_valid_q, out_valid_d;
    logic           sel_err_q, sel_err_d;
    logic           timeout_err_q, timeout_err_d;

    // Only the lane that was latched at request time is ever looked at.
    logic [N-1:0]   lane [16];
    logic [N-1:0]   lane_data;

    assign lane[0]  = a0;
    assign lane[1]  = a1;
    assign lane[2]  = a2;
    assign lane[3]  = a3;
    assign lane[4]  = a4;
    assign lane[5]  = a5;
    assign lane[6]  = a6;
    assign lane[7]  = a7;
    assign lane[8]  = a8;
    assign lane[9]  = a9;
    assign lane[10] = a10;
    assign lane[11] = a11;
    assign lane[12] = a12;
    assign lane[13] = a13;
    assign lane[14] = a14;
    assign lane[15] = a15;
    assign lane_data = lane[sel_q];

    // State and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sel_q         <= '0;
            cnt_q         <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            sel_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            sel_err_q     <= sel_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state and next-response logic.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_valid_d   = out_valid_q;
        sel_err_d     = sel_err_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                if (req) begin
                    if (fn_sel[4]) begin
                        // Illegal select: answer at once, no lane involved.
                        out_d       = '0;
                        sel_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end else begin
                        sel_d   = fn_sel[3:0];
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Lane valid is tested first so that it wins on the last count.
                if (a_valid[sel_q]) begin
                    out_d       = lane_data;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    out_d         = '0;
                    timeout_err_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                // out is left alone on completion; only the flags clear.
                if (out_valid_q && out_ready) begin
                    out_valid_d   = 1'b0;
                    sel_err_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers, so out_ready never reaches them
    // combinationally.
    always_comb begin
        out         = out_q;
        out_valid   = out_valid_q;
        sel_err     = sel_err_q;
        timeout_err = timeout_err_q;
        busy        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mux16to1_collect.sv
`timescale 1ns/1ps
// Bench for mux16to1_collect: directed collects with a transaction-level
// reference model compared on every falling edge, plus literal expectations
// for latency, data and error flags.
module tb_mux16to1_collect;

    localparam int N       = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  a [16];
    logic [15:0]   a_valid;
    logic [4:0]    fn_sel;
    logic          req;
    logic [N-1:0]  out;
    logic          out_valid;
    logic          out_ready;
    logic          sel_err;
    logic          timeout_err;
    logic          busy;

    int tests  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mux16to1_collect #(.N(N), .TIMEOUT(TIMEOUT), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .a0(a[0]),   .a1(a[1]),   .a2(a[2]),   .a3(a[3]),
        .a4(a[4]),   .a5(a[5]),   .a6(a[6]),   .a7(a[7]),
        .a8(a[8]),   .a9(a[9]),   .a10(a[10]), .a11(a[11]),
        .a12(a[12]), .a13(a[13]), .a14(a[14]), .a15(a[15]),
        .a_valid(a_valid), .fn_sel(fn_sel), .req(req),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err), .timeout_err(timeout_err), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a collect is "open" from request until hand-off; while
    // open without an answer, it counts elapsed waiting cycles.
    bit          m_open, m_answered, m_serr, m_terr;
    int          m_lane, m_waited;
    logic [N-1:0] m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_open <= 0; m_answered <= 0; m_serr <= 0; m_terr <= 0;
            m_lane <= 0; m_waited <= 0; m_data <= '0;
        end else if (!m_open) begin
            if (req) begin
                m_open <= 1;
                if (fn_sel > 15) begin
                    m_answered <= 1; m_serr <= 1; m_data <= '0;
                end else begin
                    m_lane <= int'(fn_sel); m_waited <= 0;
                end
            end
        end else if (!m_answered) begin
            if (a_valid[m_lane]) begin
                m_answered <= 1; m_data <= a[m_lane];
            end else if (m_waited + 1 >= TIMEOUT) begin
                m_answered <= 1; m_terr <= 1; m_data <= '0;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (out_ready) begin
            m_open <= 0; m_answered <= 0; m_serr <= 0; m_terr <= 0;
        end
    end

    always @(negedge clk) begin
        check("cycle", {12'd0, out, out_valid, sel_err, timeout_err, busy},
              {12'd0, m_data, m_answered, m_serr, m_terr, m_open});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    // Edges from the request-capture edge until out_valid is seen.
    task automatic wait_ov(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    int n;

    initial begin
        rst = 1'b1; req = 1'b0; fn_sel = '0; a_valid = '0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) a[i] = N'(16'h1000 + i);
        #1;
        check("reset_async", {out, out_valid, sel_err, timeout_err, busy}, 32'd0);
        step(); step();
        check("reset_state", {out, out_valid, sel_err, timeout_err, busy}, 32'd0);
        rst = 1'b0;
        step();

        // Fast data path
        fn_sel = 5'd3; a[3] = 16'hBEEF; a_valid = 16'h0008; out_ready = 1'b1;
        pulse_req();
        wait_ov(n);
        check("t1_latency", n, 2);
        check("t1_out", out, 16'hBEEF);
        check("t1_flags", {sel_err, timeout_err}, 0);
        step();
        check("t1_one_cycle", {out_valid, busy}, 0);
        check("t1_out_kept", out, 16'hBEEF);

        // Illegal select
        a_valid = '0; out_ready = 1'b0; fn_sel = 5'd20;
        pulse_req();
        wait_ov(n);
        check("t2_latency", n, 1);
        check("t2_resp", {out, sel_err, busy}, {16'h0000, 1'b1, 1'b1});
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_hold", {out_valid, sel_err, busy}, 3'b111);
        end
        out_ready = 1'b1;
        step();
        check("t2_release", {out_valid, sel_err, busy}, 0);

        // Timeout
        fn_sel = 5'd7; a_valid = 16'h0000;
        pulse_req();
        wait_ov(n);
        check("t3_latency", n, TIMEOUT + 1);
        check("t3_resp", {out, timeout_err, sel_err}, {16'h0000, 1'b1, 1'b0});
        step();
        check("t3_release", {out_valid, timeout_err, busy}, 0);

        // Late valid, select changes after capture, back-pressure
        out_ready = 1'b0; fn_sel = 5'd5; a[9] = 16'h9999; a_valid = 16'h0200;
        pulse_req();
        repeat (4) step();
        check("t4_waiting", {out_valid, busy}, 2'b01);
        fn_sel = 5'd9; a[5] = 16'h1234; a_valid = 16'h0220;
        wait_ov(n);
        check("t4_latency", n, 2);
        check("t4_out", out, 16'h1234);
        a_valid = '0; a[5] = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stable", {out, out_valid}, {16'h1234, 1'b1});
        end
        out_ready = 1'b1;
        step();
        check("t4_release", {out, out_valid, busy}, {16'h1234, 2'b00});

        // Valid arriving on the last count cycle beats the timeout
        fn_sel = 5'd12; a[12] = 16'hC0DE; a_valid = '0;
        pulse_req();
        repeat (TIMEOUT - 1) step();
        check("t5_not_yet", out_valid, 0);
        a_valid = 16'h1000;
        wait_ov(n);
        check("t5_latency", n, 2);
        check("t5_resp", {out, timeout_err}, {16'hC0DE, 1'b0});
        a_valid = '0;
        step();

        // Reset during WAIT, then during HOLD
        fn_sel = 5'd7;
        pulse_req();
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("t6_rst_wait", {out, out_valid, sel_err, timeout_err, busy}, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b0; fn_sel = 5'd20;
        pulse_req();
        check("t6_in_hold", {out_valid, sel_err}, 2'b11);
        rst = 1'b1;
        #1;
        check("t6_rst_hold", {out, out_valid, sel_err, timeout_err, busy}, 0);
        step();
        rst = 1'b0;
        step();
        fn_sel = 5'd0; a[0] = 16'h00FF; a_valid = 16'h0001; out_ready = 1'b1;
        pulse_req();
        wait_ov(n);
        check("t6_latency", n, 2);
        check("t6_out", out, 16'h00FF);
        step();
        check("t6_done", {out_valid, busy}, 0);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
